// File: rtl/sync_norm_pkg.sv
// Shared types, limits and helpers for the sync polarity normaliser.
// Channel widths are parameterised, so cnt_t/CNT_MAX describe the default build.
package sync_norm_pkg;

  localparam int DEF_CNT_W = 24;

  typedef logic [DEF_CNT_W-1:0] cnt_t;
  typedef logic [3:0]           agree_t;

  localparam cnt_t CNT_MAX = '1;

  function automatic int clog2_safe(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // Continue a run in the same direction, otherwise start a new run at 1; never exceeds limit.
  function automatic agree_t agree_next(input agree_t cur, input logic same_dir,
                                        input agree_t limit);
    agree_t base;
    base = same_dir ? cur : '0;
    return (base >= limit) ? limit : base + agree_t'(1);
  endfunction

endpackage

// File: rtl/sync_polarity_chan.sv
// One sync channel: synchroniser, phase-length counter, polarity evaluation
// with hysteresis, stale detection and a registered normalised output.
module sync_polarity_chan
  import sync_norm_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_CNT        = 3,
  parameter int OUT_ACTIVE_HIGH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic sync_out,
  output logic polarity,
  output logic locked,
  output logic stale
);

  localparam logic             OUT_IDLE = (OUT_ACTIVE_HIGH == 0);
  localparam logic [CNT_W-1:0] CNT_ALL  = '1;
  localparam logic [CNT_W-1:0] CNT_PRE  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam agree_t           LOCK_LIM = agree_t'(LOCK_CNT);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prv;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_highLen;
  logic [CNT_W-1:0]       r_lowLen;
  logic                   r_hv;
  logic                   r_lv;
  logic                   r_evalPend;
  agree_t                 r_agree;
  logic                   r_dirMis;
  logic                   r_polarity;
  logic                   r_locked;
  logic                   r_stale;
  logic                   r_syncOut;

  logic   w_cur;
  logic   w_edge;
  logic   w_cand;
  logic   w_mis;
  agree_t w_agreeNext;

  assign w_cur       = r_sync[SYNC_STAGES-1];
  assign w_edge      = w_cur ^ r_prv;
  assign w_cand      = (r_highLen > r_lowLen);
  assign w_mis       = (w_cand != r_polarity);
  assign w_agreeNext = agree_next(r_agree, (r_dirMis == w_mis), LOCK_LIM);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync     <= '0;
      r_prv      <= 1'b0;
      r_cnt      <= '0;
      r_highLen  <= '0;
      r_lowLen   <= '0;
      r_hv       <= 1'b0;
      r_lv       <= 1'b0;
      r_evalPend <= 1'b0;
      r_agree    <= '0;
      r_dirMis   <= 1'b0;
      r_polarity <= 1'b0;
      r_locked   <= 1'b0;
      r_stale    <= 1'b0;
      r_syncOut  <= OUT_IDLE;
    end else begin
      r_sync[0] <= sync_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prv      <= w_cur;
      r_evalPend <= w_edge;
      r_syncOut  <= w_cur ^ r_polarity ^ OUT_IDLE;

      // A rising edge closes a low phase, a falling edge closes a high phase.
      if (w_edge) begin
        r_cnt   <= '0;
        r_stale <= 1'b0;
        if (w_cur) begin
          r_lowLen <= r_cnt;
          r_lv     <= 1'b1;
        end else begin
          r_highLen <= r_cnt;
          r_hv      <= 1'b1;
        end
      end else if (r_cnt != CNT_ALL) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_evalPend && r_hv && r_lv) begin
        if (w_mis) begin
          if (w_agreeNext >= LOCK_LIM) begin
            r_polarity <= w_cand;
            r_agree    <= '0;
            r_locked   <= 1'b0;
            r_dirMis   <= 1'b0;
          end else begin
            r_agree  <= w_agreeNext;
            r_dirMis <= 1'b1;
          end
        end else begin
          r_agree  <= w_agreeNext;
          r_dirMis <= 1'b0;
          if (w_agreeNext >= LOCK_LIM) begin
            r_locked <= 1'b1;
          end
        end
      end

      // Counter about to saturate: measurements are meaningless, polarity is kept.
      if (!w_edge && (r_cnt == CNT_PRE)) begin
        r_stale  <= 1'b1;
        r_hv     <= 1'b0;
        r_lv     <= 1'b0;
        r_locked <= 1'b0;
        r_agree  <= '0;
      end
    end
  end

  assign sync_out = r_syncOut;
  assign polarity = r_polarity;
  assign locked   = r_locked;
  assign stale    = r_stale;

endmodule

// File: rtl/sync_polarity_norm.sv
// Multi-channel sync polarity normaliser: independent channels, fixed output polarity.
module sync_polarity_norm
  import sync_norm_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_CNT        = 3,
  parameter int OUT_ACTIVE_HIGH = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] sync_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] polarity,
  output logic [CHANNELS-1:0] locked,
  output logic [CHANNELS-1:0] stale
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    sync_polarity_chan #(
      .CNT_W          (CNT_W),
      .SYNC_STAGES    (SYNC_STAGES),
      .LOCK_CNT       (LOCK_CNT),
      .OUT_ACTIVE_HIGH(OUT_ACTIVE_HIGH)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .sync_in (sync_in[g]),
      .sync_out(sync_out[g]),
      .polarity(polarity[g]),
      .locked  (locked[g]),
      .stale   (stale[g])
    );
  end

endmodule
